// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for an 18-bit instruction set.
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK for ALU ops; JMP/HALT/illegal resolve in DECODE.
//   Fetch stalls indefinitely on imem_ack=0; every strobe is decoded from state_q/ir_q only.
// Ports:
//   clk, reset (async, active-high), start  - clocking / control
//   imem_req/imem_addr/imem_data/imem_ack    - instruction fetch handshake
//   rf_raddr1/rf_raddr2/rf_waddr/rf_we       - register-file read/write control
//   alu_select/alu_enable/imm_sel/imm_value  - ALU control and immediate operand
//   halted/illegal_op/instr_count            - status
module control_unit #(
   parameter int PC_WIDTH = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [17:0]         imem_data,
   input  logic                imem_ack,
   output logic [3:0]          rf_raddr1,
   output logic [3:0]          rf_raddr2,
   output logic [3:0]          rf_waddr,
   output logic                rf_we,
   output logic [1:0]          alu_select,
   output logic                alu_enable,
   output logic                imm_sel,
   output logic [17:0]         imm_value,
   output logic                halted,
   output logic                illegal_op,
   output logic [15:0]         instr_count
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALTED    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [17:0]         ir_q, ir_d;
   logic [15:0]         cnt_q, cnt_d;

   // Instruction fields
   logic [3:0]          opcode;
   logic [3:0]          rd;
   logic [3:0]          rs1;
   logic [3:0]          rs2;
   logic [17:0]         imm_sext;
   logic [PC_WIDTH-1:0] target;
   logic [15:0]         cnt_inc;

   assign opcode   = ir_q[17:14];
   assign rd       = ir_q[13:10];
   assign rs1      = ir_q[9:6];
   assign rs2      = ir_q[5:2];
   assign imm_sext = {{12{ir_q[5]}}, ir_q[5:0]};
   assign target   = ir_q[PC_WIDTH-1:0];

   // Retired-instruction counter sticks at all-ones rather than wrapping.
   assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   assign imem_addr   = pc_q;
   assign instr_count = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      imem_req   = 1'b0;
      rf_raddr1  = 4'd0;
      rf_raddr2  = 4'd0;
      rf_waddr   = 4'd0;
      rf_we      = 1'b0;
      alu_select = 2'b00;
      alu_enable = 1'b0;
      imm_sel    = 1'b0;
      imm_value  = 18'd0;
      halted     = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + 1'b1;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (!opcode[3]) begin
               // ALU op: opcode[2] picks immediate vs. register operand2
               rf_raddr1 = rs1;
               if (opcode[2]) begin
                  imm_sel   = 1'b1;
                  imm_value = imm_sext;
               end else begin
                  rf_raddr2 = rs2;
               end
               state_d = ST_EXECUTE;
            end else if (opcode == 4'b1000) begin
               pc_d    = target;
               cnt_d   = cnt_inc;
               state_d = ST_FETCH;
            end else if (opcode == 4'b1111) begin
               cnt_d   = cnt_inc;
               state_d = ST_HALTED;
            end else begin
               // Undefined opcode: flag it and drop the instruction.
               illegal_op = 1'b1;
               state_d    = ST_FETCH;
            end
         end

         ST_EXECUTE: begin
            // Only ALU ops reach here, so opcode[3] is known to be 0.
            alu_enable = 1'b1;
            alu_select = opcode[1:0];
            imm_sel    = opcode[2];
            rf_raddr1  = rs1;
            if (opcode[2]) imm_value = imm_sext;
            else           rf_raddr2 = rs2;
            state_d    = ST_WRITEBACK;
         end

         ST_WRITEBACK: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            cnt_d    = cnt_inc;
            state_d  = ST_FETCH;
         end

         ST_HALTED: begin
            halted = 1'b1;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed program run through control_unit with a queue scoreboard.
//   Expected fetch/execute/writeback/illegal events are queued as stimulus is loaded;
//   a monitor on the falling edge pops and compares each event the DUT presents.
module tb_control_unit;

   localparam int PW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic [17:0]   imem_data;
   logic          imem_ack;
   logic [3:0]    rf_raddr1, rf_raddr2, rf_waddr;
   logic          rf_we;
   logic [1:0]    alu_select;
   logic          alu_enable, imm_sel;
   logic [17:0]   imm_value;
   logic          halted, illegal_op;
   logic [15:0]   instr_count;

   logic [17:0]   mem [0:(1<<PW)-1];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_ack = 0;

   localparam int EV_FETCH = 0, EV_EXEC = 1, EV_WB = 2, EV_ILL = 3;

   typedef struct {
      int          kind;
      logic [PW-1:0] addr;
      logic [1:0]  sel;
      logic        isel;
      logic [3:0]  r1;
      logic [3:0]  r2;
      logic [17:0] imm;
      logic [3:0]  waddr;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   control_unit #(.PC_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
      .alu_select(alu_select), .alu_enable(alu_enable), .imm_sel(imm_sel), .imm_value(imm_value),
      .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign imem_data = mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t blank(input int kind);
      exp_t e;
      e.kind = kind; e.addr = '0; e.sel = 2'b00; e.isel = 1'b0; e.r1 = 4'd0;
      e.r2 = 4'd0; e.imm = 18'd0; e.waddr = 4'd0; e.cnt = 16'd0;
      return e;
   endfunction

   task automatic push_fetch(input logic [PW-1:0] a);
      exp_t e = blank(EV_FETCH);
      e.addr = a;
      sb.push_back(e);
   endtask

   task automatic push_exec(input logic [1:0] s, input logic is, input logic [3:0] r1,
                            input logic [3:0] r2, input logic [17:0] imm);
      exp_t e = blank(EV_EXEC);
      e.sel = s; e.isel = is; e.r1 = r1; e.r2 = r2; e.imm = imm;
      sb.push_back(e);
   endtask

   task automatic push_wb(input logic [3:0] wa, input logic [15:0] c);
      exp_t e = blank(EV_WB);
      e.waddr = wa; e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic push_ill(input logic [15:0] c);
      exp_t e = blank(EV_ILL);
      e.cnt = c;
      sb.push_back(e);
   endtask

   // Monitor: one DUT event per cycle at most, since each strobe belongs to one state.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         int   kind;
         exp_t e;
         kind = -1;
         if (imem_req && imem_ack) kind = EV_FETCH;
         else if (alu_enable)      kind = EV_EXEC;
         else if (rf_we)           kind = EV_WB;
         else if (illegal_op)      kind = EV_ILL;
         if (kind >= 0) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_event: got kind %0d with empty queue (cycle %0d)", kind, cyc);
            end else begin
               e = sb.pop_front();
               chk("event_kind", kind, e.kind);
               case (kind)
                  EV_FETCH: begin
                     chk("fetch_addr", imem_addr, e.addr);
                     last_ack = cyc;
                  end
                  EV_EXEC: begin
                     chk("exec_latency", cyc - last_ack, 2);
                     chk("exec_alu_select", alu_select, e.sel);
                     chk("exec_imm_sel", imm_sel, e.isel);
                     chk("exec_raddr1", rf_raddr1, e.r1);
                     chk("exec_raddr2", rf_raddr2, e.r2);
                     chk("exec_imm_value", imm_value, e.imm);
                  end
                  EV_WB: begin
                     chk("wb_latency", cyc - last_ack, 3);
                     chk("wb_waddr", rf_waddr, e.waddr);
                     chk("wb_count_before", instr_count, e.cnt);
                  end
                  default: begin
                     chk("ill_latency", cyc - last_ack, 1);
                     chk("ill_count", instr_count, e.cnt);
                  end
               endcase
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_imem_req"}, imem_req, 0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_strobes"}, {rf_we, alu_enable, imm_sel, halted, illegal_op}, 0);
      chk({tag, "_addrs"}, {rf_raddr1, rf_raddr2, rf_waddr}, 0);
      chk({tag, "_alu_select"}, alu_select, 0);
      chk({tag, "_imm_value"}, imm_value, 0);
      chk({tag, "_instr_count"}, instr_count, 0);
   endtask

   initial begin
      logic found;
      reset = 1'b1; start = 1'b0; imem_ack = 1'b1;
      for (int i = 0; i < (1 << PW); i++) mem[i] = 18'd0;

      // Program: ADD r3,r1,r2 ; NORI r5,r4,-2 ; illegal 1010 ; JMP 0x3FF ; @0x3FF AND r7,r6,r5
      mem[0]     = 18'b0000_0011_0001_0010_00;
      mem[1]     = {4'b0111, 4'd5, 4'd4, 6'b111110};
      mem[2]     = {4'b1010, 14'd0};
      mem[3]     = {4'b1000, 4'd0, 10'h3FF};
      mem[10'h3FF] = {4'b0001, 4'd7, 4'd6, 4'd5, 2'b00};

      push_fetch(10'd0);   push_exec(2'b00, 1'b0, 4'd1, 4'd2, 18'd0);       push_wb(4'd3, 16'd0);
      push_fetch(10'd1);   push_exec(2'b11, 1'b1, 4'd4, 4'd0, 18'h3FFFE);   push_wb(4'd5, 16'd1);
      push_fetch(10'd2);   push_ill(16'd2);
      push_fetch(10'd3);
      push_fetch(10'h3FF); push_exec(2'b01, 1'b0, 4'd6, 4'd5, 18'd0);       push_wb(4'd7, 16'd3);

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("idle_no_req", imem_req, 0);
      end

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;

      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (rf_we && rf_waddr == 4'd7) found = 1'b1;
      end
      chk("wait_and_writeback", found, 1);

      // Stall the fetch that follows the wrap to 0, and turn that word into HALT.
      #1 imem_ack = 1'b0;
      mem[0] = {4'b1111, 14'd0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_req", imem_req, 1);
         chk("stall_addr_wrapped", imem_addr, 0);
         chk("stall_no_strobes", {alu_enable, rf_we, illegal_op, halted}, 0);
      end
      push_fetch(10'd0);
      @(posedge clk); #1 imem_ack = 1'b1;

      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (halted) found = 1'b1;
      end
      chk("wait_halted", found, 1);
      chk("halt_count", instr_count, 5);
      chk("phaseA_queue_empty", sb.size(), 0);

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("halted_sticky", halted, 1);
         chk("halted_quiet", {imem_req, alu_enable, rf_we, illegal_op}, 0);
         chk("halted_count", instr_count, 5);
      end

      // Reset during EXECUTE: no writeback may follow.
      @(posedge clk); #1 reset = 1'b1;
      mem[0] = 18'b0000_0011_0001_0010_00;
      @(posedge clk); #1;
      check_all_zero("reset_from_halt");
      reset = 1'b0;
      push_fetch(10'd0);
      push_exec(2'b00, 1'b0, 4'd1, 4'd2, 18'd0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;

      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (alu_enable) found = 1'b1;
      end
      chk("wait_execute", found, 1);
      #1 reset = 1'b1;
      #1;
      check_all_zero("reset_mid_exec");
      @(posedge clk); #1 reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("post_reset_idle", {imem_req, rf_we, alu_enable, halted}, 0);
         chk("post_reset_count", instr_count, 0);
      end

      chk("final_queue_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
